// File: rtl/seg_display_sequencer_if.sv
// Signal bundle between the game logic and the seven-segment display sequencer.
// The game side drives status and score; the sequencer drives anodes, segments and frame_start.
interface seg_display_sequencer_if;
   logic        game_active;
   logic        lost;
   logic [15:0] score_bcd;
   logic [3:0]  Anode_Activate;
   logic [6:0]  LED_out;
   logic        frame_start;

   modport master (
      output game_active, lost, score_bcd,
      input  Anode_Activate, LED_out, frame_start
   );

   modport slave (
      input  game_active, lost, score_bcd,
      output Anode_Activate, LED_out, frame_start
   );
endinterface

// File: rtl/seg_display_sequencer.sv
// Four-digit active-low seven-segment controller: score, blinking YOU/LOSE after a loss,
// dashes when idle. Digit scan and message phases are both divided down from clk.
module seg_display_sequencer #(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned PHASE_DIV = 50000000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seg_display_sequencer_if.slave dsp
);

   localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
   localparam int unsigned PHASE_W = $clog2(PHASE_DIV);

   localparam logic [6:0] G_DASH  = 7'b1111110;
   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_Y     = 7'b1000100;
   localparam logic [6:0] G_O     = 7'b0000001;
   localparam logic [6:0] G_U     = 7'b1000001;
   localparam logic [6:0] G_L     = 7'b1110001;
   localparam logic [6:0] G_S     = 7'b0100100;
   localparam logic [6:0] G_E     = 7'b0110000;

   typedef enum logic [2:0] {IDLE, PLAY, L_YOU, L_GAP1, L_LOSE, L_GAP2} state_t;

   state_t               state, state_n;
   logic [SCAN_W-1:0]    scan_cnt;
   logic [PHASE_W-1:0]   phase_cnt;
   logic [1:0]           idx;
   logic [15:0]          score_q;
   logic [3:0]           anode_q, anode_n;
   logic [6:0]           led_q, led_n;
   logic                 frame_q;
   logic                 scan_tc, phase_tc, wrap, in_lost;
   logic [3:0]           nib;
   logic [3:0]           lead_zero;

   function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
      case (d)
         4'd0:    bcd_glyph = 7'b0000001;
         4'd1:    bcd_glyph = 7'b1001111;
         4'd2:    bcd_glyph = 7'b0010010;
         4'd3:    bcd_glyph = 7'b0000110;
         4'd4:    bcd_glyph = 7'b1001100;
         4'd5:    bcd_glyph = 7'b0100100;
         4'd6:    bcd_glyph = 7'b0100000;
         4'd7:    bcd_glyph = 7'b0001111;
         4'd8:    bcd_glyph = 7'b0000000;
         4'd9:    bcd_glyph = 7'b0000100;
         default: bcd_glyph = G_DASH;
      endcase
   endfunction

   assign scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign phase_tc = (phase_cnt == PHASE_W'(PHASE_DIV - 1));
   assign wrap     = scan_tc && (idx == 2'd3);
   assign in_lost  = (state == L_YOU) || (state == L_GAP1) ||
                     (state == L_LOSE) || (state == L_GAP2);

   // lead_zero[i]: digit i and everything left of it are zero; rightmost is never blanked.
   assign lead_zero[0] = (score_q[15:12] == 4'd0);
   assign lead_zero[1] = lead_zero[0] && (score_q[11:8] == 4'd0);
   assign lead_zero[2] = lead_zero[1] && (score_q[7:4] == 4'd0);
   assign lead_zero[3] = 1'b0;

   always_comb begin
      state_n = state;
      anode_n = ~(4'b1000 >> idx);
      led_n   = G_BLANK;
      nib     = '0;

      case (state)
         IDLE: begin
            if (dsp.lost)             state_n = L_YOU;
            else if (dsp.game_active) state_n = PLAY;
         end
         PLAY: begin
            if (dsp.lost)              state_n = L_YOU;
            else if (!dsp.game_active) state_n = IDLE;
         end
         default: begin
            if (!dsp.lost) begin
               state_n = dsp.game_active ? PLAY : IDLE;
            end else if (phase_tc) begin
               case (state)
                  L_YOU:   state_n = L_GAP1;
                  L_GAP1:  state_n = L_LOSE;
                  L_LOSE:  state_n = L_GAP2;
                  default: state_n = L_YOU;
               endcase
            end
         end
      endcase

      case (idx)
         2'd0:    nib = score_q[15:12];
         2'd1:    nib = score_q[11:8];
         2'd2:    nib = score_q[7:4];
         default: nib = score_q[3:0];
      endcase

      case (state)
         IDLE: led_n = G_DASH;
         PLAY: led_n = lead_zero[idx] ? G_BLANK : bcd_glyph(nib);
         L_YOU: begin
            case (idx)
               2'd1:    led_n = G_Y;
               2'd2:    led_n = G_O;
               2'd3:    led_n = G_U;
               default: led_n = G_BLANK;
            endcase
         end
         L_LOSE: begin
            case (idx)
               2'd0:    led_n = G_L;
               2'd1:    led_n = G_O;
               2'd2:    led_n = G_S;
               default: led_n = G_E;
            endcase
         end
         default: led_n = G_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         scan_cnt  <= '0;
         phase_cnt <= '0;
         idx       <= '0;
         score_q   <= '0;
         anode_q   <= '1;
         led_q     <= '1;
         frame_q   <= 1'b0;
      end else begin
         state    <= state_n;
         scan_cnt <= scan_tc ? '0 : scan_cnt + SCAN_W'(1);
         if (scan_tc) idx <= idx + 2'd1;
         frame_q  <= wrap;
         // Frame wrap and PLAY entry share one latch so a coincident event loads once.
         if (wrap || (state_n == PLAY && state != PLAY)) score_q <= dsp.score_bcd;
         phase_cnt <= (in_lost && dsp.lost && !phase_tc) ? phase_cnt + PHASE_W'(1) : '0;
         anode_q  <= anode_n;
         led_q    <= led_n;
      end
   end

   assign dsp.Anode_Activate = anode_q;
   assign dsp.LED_out        = led_q;
   assign dsp.frame_start    = frame_q;

endmodule

// File: tb/tb_seg_display_sequencer.sv
// Self-checking bench: edge-count arithmetic reference model compared every cycle,
// plus literal frame checks for the main display modes.
module tb_seg_display_sequencer;
   localparam int unsigned SD = 4;
   localparam int unsigned PD = 64;

   localparam logic [6:0] DASH  = 7'b1111110;
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DIG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100};
   localparam logic [6:0] YOU_G  [4] = '{7'b1111111, 7'b1000100, 7'b0000001, 7'b1000001};
   localparam logic [6:0] LOSE_G [4] = '{7'b1110001, 7'b0000001, 7'b0100100, 7'b0110000};

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   bit   chk_en = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   seg_display_sequencer_if bus();

   seg_display_sequencer #(.SCAN_DIV(SD), .PHASE_DIV(PD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .dsp  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: mode is a pure function of inputs; digit slot and message phase
   // follow from the number of edges since reset and since the loss began.
   int unsigned n = 0;
   int unsigned e = 0;
   int unsigned pi, ph;
   int          mode = 0, nm;
   logic [15:0] sq = '0;
   logic [3:0]  exp_anode = 4'hF;
   logic [6:0]  exp_led = 7'h7F;
   logic        exp_fs = 1'b0;

   function automatic logic [6:0] view(input int m, input int unsigned p,
                                       input logic [15:0] s, input int unsigned d);
      logic [15:0] upper;
      logic [3:0]  nb;
      if (m == 0) return DASH;
      if (m == 2) begin
         if (p == 0) return YOU_G[d];
         if (p == 2) return LOSE_G[d];
         return BLANK;
      end
      upper = s >> (4 * (3 - d));
      nb    = upper[3:0];
      if (d < 3 && upper == 16'd0) return BLANK;
      if (nb > 9) return DASH;
      return DIG[nb];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; e = 0; mode = 0; sq = '0;
         exp_anode = 4'hF; exp_led = 7'h7F; exp_fs = 1'b0;
      end else begin
         n = n + 1;
         pi = ((n - 1) / SD) % 4;
         ph = ((n - 1 - e) / PD) % 4;
         exp_anode = ~(4'b1000 >> pi);
         exp_led   = view(mode, ph, sq, pi);
         exp_fs    = (n % (4 * SD)) == 0;
         nm = bus.lost ? 2 : (bus.game_active ? 1 : 0);
         if (nm == 2 && mode != 2) e = n;
         if ((nm == 1 && mode != 1) || exp_fs) sq = bus.score_bcd;
         mode = nm;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("anode", 32'(bus.Anode_Activate), 32'(exp_anode));
         check("led", 32'(bus.LED_out), 32'(exp_led));
         check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
      end
   end

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait expired, required event not seen", name);
   endtask

   task automatic wait_anode(input logic [3:0] pat, output bit ok);
      int t = 0;
      @(negedge clk);
      while (bus.Anode_Activate !== pat && t < 64) begin
         @(negedge clk);
         t++;
      end
      ok = (t < 64);
   endtask

   task automatic frame_chk(input string name, input logic [27:0] req);
      logic [27:0] f = '0;
      bit ok;
      for (int d = 0; d < 4; d++) begin
         wait_anode(~(4'b1000 >> d), ok);
         if (!ok) begin
            timeout(name);
            return;
         end
         f = {f[20:0], bus.LED_out};
      end
      check(name, 32'(f), 32'(req));
   endtask

   function automatic logic [15:0] rand_score();
      logic [15:0] s;
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      for (int i = 0; i < 4; i++) s[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) s[15:8] = 8'h00;
      return s;
   endfunction

   initial begin
      bit ok;
      int t;
      bus.game_active = 1'b0;
      bus.lost        = 1'b0;
      bus.score_bcd   = 16'h0000;

      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      check("reset_anode", 32'(bus.Anode_Activate), 32'h0000000F);
      check("reset_led", 32'(bus.LED_out), 32'h0000007F);
      check("reset_fs", 32'(bus.frame_start), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_anode", 32'(bus.Anode_Activate), 32'h00000007);
      check("first_led", 32'(bus.LED_out), 32'(DASH));

      t = 0;
      while (bus.frame_start !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      if (t >= 40) timeout("fs_first");
      t = 0;
      do begin @(negedge clk); t++; end while (bus.frame_start !== 1'b1 && t < 40);
      check("fs_period", 32'(t), 32'd16);

      frame_chk("idle_frame", {DASH, DASH, DASH, DASH});

      bus.game_active = 1'b1;
      bus.score_bcd   = 16'h0042;
      repeat (20) @(negedge clk);
      frame_chk("play_0042", {BLANK, BLANK, 7'b1001100, 7'b0010010});
      bus.score_bcd = 16'h0000;
      repeat (20) @(negedge clk);
      frame_chk("play_0000", {BLANK, BLANK, BLANK, 7'b0000001});
      bus.score_bcd = 16'h0A05;
      repeat (20) @(negedge clk);
      frame_chk("play_0A05", {BLANK, DASH, 7'b0000001, 7'b0100100});

      bus.score_bcd = 16'h1234;
      repeat (20) @(negedge clk);
      wait_anode(4'b1011, ok);
      if (!ok) timeout("midframe_sync");
      bus.score_bcd = 16'h5678;
      wait_anode(4'b1101, ok);
      check("midframe_d2", 32'(bus.LED_out), 32'(7'b0000110));
      wait_anode(4'b1110, ok);
      check("midframe_d3", 32'(bus.LED_out), 32'(7'b1001100));
      frame_chk("play_5678", {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000});

      bus.game_active = 1'b0;
      bus.lost        = 1'b1;
      repeat (20) @(negedge clk);
      frame_chk("you_frame", {BLANK, 7'b1000100, 7'b0000001, 7'b1000001});
      repeat (120) @(negedge clk);
      frame_chk("lose_frame", {7'b1110001, 7'b0000001, 7'b0100100, 7'b0110000});

      bus.lost = 1'b0;
      repeat (2) @(negedge clk);
      check("exit_idle_led", 32'(bus.LED_out), 32'(DASH));

      bus.lost      = 1'b1;
      bus.score_bcd = 16'h0042;
      repeat (140) @(negedge clk);
      bus.lost        = 1'b0;
      bus.game_active = 1'b1;
      repeat (20) @(negedge clk);
      frame_chk("exit_play_0042", {BLANK, BLANK, 7'b1001100, 7'b0010010});

      bus.game_active = 1'b0;
      bus.lost        = 1'b1;
      repeat (140) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_anode", 32'(bus.Anode_Activate), 32'h0000000F);
      check("async_led", 32'(bus.LED_out), 32'h0000007F);
      @(negedge clk);
      bus.lost = 1'b0;
      rst_n    = 1'b1;
      @(negedge clk);
      check("rerelease_anode", 32'(bus.Anode_Activate), 32'h00000007);
      check("rerelease_led", 32'(bus.LED_out), 32'(DASH));

      for (int s = 0; s < 40; s++) begin
         int unsigned hold;
         bus.lost        = ($urandom_range(0, 9) < 3);
         bus.game_active = 1'($urandom_range(0, 1));
         bus.score_bcd   = rand_score();
         hold = (bus.lost && $urandom_range(0, 1) == 1) ? $urandom_range(150, 300)
                                                        : $urandom_range(1, 60);
         repeat (hold) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) bus.score_bcd = rand_score();
         end
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
